tlp_beat_serializer: RTL and testbench
======================================

// Module: tlp_beat_serializer
// PURPOSE
//  Consumes whole memory-write TLPs (header + CHUNK_MAX_BEATS payload beats) from the AXI-write-to-TLP
//  stage, whose one-cycle tlp_valid pulse has no backpressure. Buffers them in a small FIFO and
//  streams each one as DATA_WIDTH beats on a valid/ready link toward the PCIe TX path.
//  Beat 0 carries the header; beats 1..CHUNK_MAX_BEATS carry the payload.
//  Drops and counts TLPs that arrive while the FIFO is full.
// PARAMETERS
//  DATA_WIDTH       256  width of one output beat
//  CHUNK_MAX_BEATS  4    payload beats per TLP
//  HDR_WIDTH        128  $bits(tlp_memory_req_header); must be <= DATA_WIDTH
//  FIFO_DEPTH       2    TLP entries buffered; power of 2, >= 2
// PORTS
//  clk            in   1                                clock
//  rst            in   1                                synchronous active-high reset
//  in_tlp_valid   in   1                                1-cycle push strobe (no ready)
//  in_tlp         in   HDR_WIDTH+DATA_WIDTH*CHUNK_MAX_BEATS  {header, payload}; header in MSBs
//  in_space_avail out  1                                FIFO not full (status only)
//  out_valid      out  1                                beat valid
//  out_ready      in   1                                downstream accepts beat
//  out_data       out  DATA_WIDTH                       beat data
//  out_sop        out  1                                first beat (header) of a TLP
//  out_eop        out  1                                last payload beat of a TLP
//  tlp_sent_cnt   out  16                               TLPs fully sent; wraps at 2^16
//  drop_cnt       out  16                               TLPs dropped; saturates at 16'hFFFF
//  overflow       out  1                                sticky: any drop since reset
// BEHAVIOUR
//  - Reset (rst=1 at a clk edge): FIFO emptied; beat_idx=0; counters=0; overflow=0.
//    Next cycle: out_valid=0, out_sop=0, out_eop=0, out_data=0, in_space_avail=1.
//  - Reset mid-TLP abandons the partial TLP. No further beats of that TLP are sent.
//  - Push: in_tlp_valid=1 at an edge writes in_tlp to the FIFO tail.
//    Push is accepted if not full, or if full and the final-beat pop occurs on the same edge.
//    Otherwise the TLP is dropped: drop_cnt+1 (saturating), overflow<=1, FIFO unchanged.
//  - Latency: push at edge N -> out_valid=1 with the header beat in the cycle after edge N,
//    if the FIFO was previously empty.
//  - Output path: out_valid = FIFO non-empty. beat_idx (0..CHUNK_MAX_BEATS) selects the beat
//    from the FIFO head:
//      beat 0: out_data = {header, (DATA_WIDTH-HDR_WIDTH) zeros}; out_sop=1.
//      beat k (1..CHUNK_MAX_BEATS): out_data = payload[(CHUNK_MAX_BEATS-k+1)*DATA_WIDTH-1 -: DATA_WIDTH].
//        Beat 1 is the most-significant payload slice, i.e. upstream's first AXI beat.
//      out_eop=1 only when beat_idx==CHUNK_MAX_BEATS.
//  - Handshake at out_valid & out_ready:
//      beat_idx+1, or on eop: beat_idx<=0, FIFO pop, tlp_sent_cnt+1 (wrapping).
//  - Stall rule: while out_valid=1 and out_ready=0, out_data/out_sop/out_eop are held stable.
//    out_valid never drops before the handshake.
//  - out_data is don't-care (driven 0) when out_valid=0. No bubbles between back-to-back TLPs.
//  - Counters are in bits; pointer arithmetic is log2(FIFO_DEPTH)+1 bits with wrap.
//    full = MSBs differ and LSBs equal.
//  - Simultaneous push into an empty FIFO while idle: accepted; first beat appears the next cycle.
// TESTING
//  1. One TLP (hdr=128'h1234, payload beats A..D = 256'hA.., 256'hB.., ...), out_ready=1
//     -> 5 beats: hdr<<128 (sop), A, B, C, D (eop); tlp_sent_cnt=1.
//  2. Same TLP, out_ready pattern 1,0,1,0... -> each beat held while stalled;
//     exactly 5 handshakes, no duplicates.
//  3. Two pushes 1 cycle apart, out_ready=1 -> 10 contiguous beats; sop on beats 0 and 5;
//     order preserved; tlp_sent_cnt=2.
//  4. out_ready=0, three pushes, FIFO_DEPTH=2 -> third dropped: drop_cnt=1, overflow=1,
//     in_space_avail=0. Then out_ready=1 -> first two TLPs out in order.
//  5. FIFO full; push on the same edge as the eop handshake -> accepted, drop_cnt unchanged,
//     new TLP follows without a bubble.
//  6. rst pulse after payload beat 2 handshake -> next cycle out_valid=0, counters 0;
//     new push starts with a sop header beat.

Source files
------------

// File: rtl/tlp_beat_serializer.sv
// rtl/tlp_beat_serializer.sv - buffers whole memory-write TLPs and streams them as header + payload beats
module tlp_beat_serializer #(
  parameter int DATA_WIDTH      = 256,
  parameter int CHUNK_MAX_BEATS = 4,
  parameter int HDR_WIDTH       = 128,
  parameter int FIFO_DEPTH      = 2
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          in_tlp_valid,
  input  logic [HDR_WIDTH+DATA_WIDTH*CHUNK_MAX_BEATS-1:0] in_tlp,
  output logic                                          in_space_avail,
  output logic                                          out_valid,
  input  logic                                          out_ready,
  output logic [DATA_WIDTH-1:0]                         out_data,
  output logic                                          out_sop,
  output logic                                          out_eop,
  output logic [15:0]                                   tlp_sent_cnt,
  output logic [15:0]                                   drop_cnt,
  output logic                                          overflow
);

  localparam int TLP_W = HDR_WIDTH + DATA_WIDTH * CHUNK_MAX_BEATS;
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int BW    = $clog2(CHUNK_MAX_BEATS + 1);

  logic [TLP_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [BW-1:0]    beat_idx_q, beat_idx_d;
  logic [15:0]      sent_q, sent_d;
  logic [15:0]      drop_q, drop_d;
  logic             ovf_q, ovf_d;

  logic             empty, full, hs, pop, push_ok, drop;
  logic [TLP_W-1:0] head;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head  = mem_q[rd_ptr_q[AW-1:0]];

  assign in_space_avail = !full;
  assign out_valid      = !empty;
  assign tlp_sent_cnt   = sent_q;
  assign drop_cnt       = drop_q;
  assign overflow       = ovf_q;

  // Beat 1 is the most-significant payload slice (upstream's first AXI beat).
  always_comb begin
    out_data = '0;
    out_sop  = 1'b0;
    out_eop  = 1'b0;
    if (!empty) begin
      if (beat_idx_q == '0) begin
        out_data = DATA_WIDTH'(head[TLP_W-1 -: HDR_WIDTH]) << (DATA_WIDTH - HDR_WIDTH);
        out_sop  = 1'b1;
      end
      for (int k = 1; k <= CHUNK_MAX_BEATS; k++) begin
        if (beat_idx_q == BW'(k)) begin
          out_data = head[(CHUNK_MAX_BEATS-k+1)*DATA_WIDTH-1 -: DATA_WIDTH];
        end
      end
      out_eop = (beat_idx_q == BW'(CHUNK_MAX_BEATS));
    end
  end

  // A full FIFO still accepts a push on the edge that retires its head.
  always_comb begin
    hs         = out_valid && out_ready;
    pop        = hs && out_eop;
    push_ok    = in_tlp_valid && (!full || pop);
    drop       = in_tlp_valid && !push_ok;
    beat_idx_d = beat_idx_q;
    if (hs) begin
      beat_idx_d = out_eop ? '0 : beat_idx_q + 1'b1;
    end
    wr_ptr_d = wr_ptr_q + (AW+1)'(push_ok);
    rd_ptr_d = rd_ptr_q + (AW+1)'(pop);
    sent_d   = sent_q + 16'(pop);
    drop_d   = (drop && drop_q != 16'hFFFF) ? drop_q + 16'd1 : drop_q;
    ovf_d    = ovf_q | drop;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      beat_idx_q <= '0;
      sent_q     <= '0;
      drop_q     <= '0;
      ovf_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      beat_idx_q <= beat_idx_d;
      sent_q     <= sent_d;
      drop_q     <= drop_d;
      ovf_q      <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !rst) begin
      mem_q[wr_ptr_q[AW-1:0]] <= in_tlp;
    end
  end

endmodule

// File: tb/tb_tlp_beat_serializer.sv
// tb/tb_tlp_beat_serializer.sv - scoreboard bench for tlp_beat_serializer
module tb_tlp_beat_serializer;

  localparam int DW = 256;
  localparam int NB = 4;
  localparam int HW = 128;
  localparam int FD = 2;
  localparam int TW = HW + DW * NB;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_tlp_valid = 1'b0;
  logic [TW-1:0] in_tlp = '0;
  logic          in_space_avail;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic          out_sop, out_eop;
  logic [15:0]   tlp_sent_cnt, drop_cnt;
  logic          overflow;

  typedef struct packed {
    logic          sop;
    logic          eop;
    logic [DW-1:0] data;
  } beat_t;

  beat_t sb[$];
  int    total = 0;
  int    bad   = 0;
  int    hs    = 0;
  int    hs0;
  logic  prev_stall = 1'b0;
  beat_t prev_beat;

  tlp_beat_serializer #(.DATA_WIDTH(DW), .CHUNK_MAX_BEATS(NB), .HDR_WIDTH(HW), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst(rst), .in_tlp_valid(in_tlp_valid), .in_tlp(in_tlp),
    .in_space_avail(in_space_avail), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_sop(out_sop), .out_eop(out_eop),
    .tlp_sent_cnt(tlp_sent_cnt), .drop_cnt(drop_cnt), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] pay_beat(input logic [7:0] tag, input int k);
    logic [7:0] b;
    b = 8'hA0 + 8'(k);
    return {16{tag, b}};
  endfunction

  function automatic logic [HW-1:0] hdr_of(input logic [7:0] tag);
    return 128'h1234 | {tag, 120'h0};
  endfunction

  task automatic push_tlp(input logic [7:0] tag, input bit accept);
    logic [TW-1:0] t;
    beat_t b;
    t = '0;
    t[TW-1 -: HW] = hdr_of(tag);
    for (int k = 1; k <= NB; k++) t[(NB-k)*DW +: DW] = pay_beat(tag, k);
    if (accept) begin
      b.sop = 1'b1; b.eop = 1'b0; b.data = {hdr_of(tag), {(DW-HW){1'b0}}};
      sb.push_back(b);
      for (int k = 1; k <= NB; k++) begin
        b.sop = 1'b0; b.eop = (k == NB); b.data = pay_beat(tag, k);
        sb.push_back(b);
      end
    end
    in_tlp = t;
    in_tlp_valid = 1'b1;
    step();
    in_tlp_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    bit done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      if (sb.size() == 0 && !out_valid) done = 1'b1;
      else step();
    end
    chk(tag, DW'(done), DW'(1));
  endtask

  task automatic wait_hs(input int target, input string tag);
    for (int i = 0; i < 50 && hs < target; i++) step();
    chk(tag, DW'(hs >= target), DW'(1));
  endtask

  always @(negedge clk) begin
    beat_t e;
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", DW'(out_valid), DW'(1));
        chk("stall_data", out_data, prev_beat.data);
        chk("stall_flags", DW'({out_sop, out_eop}), DW'({prev_beat.sop, prev_beat.eop}));
      end
      if (out_valid && out_ready) begin
        hs++;
        total++;
        assert (sb.size() != 0) else begin
          bad++;
          $error("FAIL unexpected_beat observed=%h expected=none", out_data);
        end
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("beat_data", out_data, e.data);
          chk("beat_flags", DW'({out_sop, out_eop}), DW'({e.sop, e.eop}));
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_beat.sop = out_sop; prev_beat.eop = out_eop; prev_beat.data = out_data;
    end
  end

  initial begin
    step(); step();
    rst = 1'b0;
    chk("rst_valid", DW'(out_valid), DW'(0));
    chk("rst_flags", DW'({out_sop, out_eop}), DW'(0));
    chk("rst_data", out_data, '0);
    chk("rst_space", DW'(in_space_avail), DW'(1));
    chk("rst_cnts", DW'({tlp_sent_cnt, drop_cnt, overflow}), DW'(0));

    // 1: single TLP, always ready; header appears one cycle after push
    out_ready = 1'b1;
    push_tlp(8'h01, 1'b1);
    chk("t1_latency_valid", DW'(out_valid), DW'(1));
    chk("t1_latency_sop", DW'(out_sop), DW'(1));
    drain("t1_drain");
    chk("t1_sent", DW'(tlp_sent_cnt), DW'(1));

    // 2: alternating ready, exactly five handshakes
    hs0 = hs;
    push_tlp(8'h02, 1'b1);
    for (int i = 0; i < 40 && (sb.size() != 0 || out_valid); i++) begin
      out_ready = ~out_ready;
      step();
    end
    chk("t2_hs", DW'(hs - hs0), DW'(5));
    chk("t2_sent", DW'(tlp_sent_cnt), DW'(2));

    // 3: back-to-back pushes stream 10 contiguous beats
    out_ready = 1'b1;
    step();
    hs0 = hs;
    push_tlp(8'h03, 1'b1);
    push_tlp(8'h04, 1'b1);
    repeat (9) step();
    chk("t3_contiguous", DW'(hs - hs0), DW'(10));
    drain("t3_drain");
    chk("t3_sent", DW'(tlp_sent_cnt), DW'(4));

    // 4: third push into a full FIFO is dropped
    out_ready = 1'b0;
    push_tlp(8'h05, 1'b1);
    push_tlp(8'h06, 1'b1);
    push_tlp(8'h07, 1'b0);
    chk("t4_drop", DW'(drop_cnt), DW'(1));
    chk("t4_ovf", DW'(overflow), DW'(1));
    chk("t4_space", DW'(in_space_avail), DW'(0));
    out_ready = 1'b1;
    drain("t4_drain");
    chk("t4_sent", DW'(tlp_sent_cnt), DW'(6));

    // 5: push on the eop edge of a full FIFO is accepted with no bubble
    out_ready = 1'b0;
    push_tlp(8'h08, 1'b1);
    push_tlp(8'h09, 1'b1);
    chk("t5_full", DW'(in_space_avail), DW'(0));
    hs0 = hs;
    out_ready = 1'b1;
    wait_hs(hs0 + 4, "t5_wait");
    chk("t5_at_eop", DW'(out_eop), DW'(1));
    push_tlp(8'h0A, 1'b1);
    repeat (10) step();
    chk("t5_contiguous", DW'(hs - hs0), DW'(15));
    chk("t5_drop", DW'(drop_cnt), DW'(1));
    drain("t5_drain");
    chk("t5_sent", DW'(tlp_sent_cnt), DW'(9));

    // 6: reset after payload beat 2 abandons the TLP
    hs0 = hs;
    push_tlp(8'h0B, 1'b1);
    wait_hs(hs0 + 3, "t6_wait");
    rst = 1'b1;
    sb.delete();
    step();
    rst = 1'b0;
    chk("t6_valid", DW'(out_valid), DW'(0));
    chk("t6_data", out_data, '0);
    chk("t6_cnts", DW'({tlp_sent_cnt, drop_cnt, overflow}), DW'(0));
    chk("t6_space", DW'(in_space_avail), DW'(1));
    push_tlp(8'h0C, 1'b1);
    chk("t6_sop", DW'(out_sop), DW'(1));
    drain("t6_drain");
    chk("t6_sent", DW'(tlp_sent_cnt), DW'(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
